majority_voter: RTL and testbench
=================================

Name: majority_voter

Overview:
- Registered triple-modular-redundancy (TMR) majority voter.
- Takes three redundant copies of a WIDTH-bit signal and outputs the bitwise 2-of-3 majority one clock later.
- Reports, per lane, whether that lane disagreed with the voted result, and keeps saturating per-lane fault counters for health monitoring.
- Sits between triplicated logic and its single downstream consumer.

Parameters:
- WIDTH, 1, bit width of each voted lane and of y.
- CNT_W, 8, width of each per-lane fault counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  redundant lane A.
- b  input  WIDTH  redundant lane B.
- c  input  WIDTH  redundant lane C.
- in_valid  input  1  lanes a/b/c are sampled and voted this cycle.
- clr_cnt  input  1  synchronous clear of all fault counters.
- y  output  WIDTH  registered bitwise majority result.
- y_valid  output  1  y was updated by a vote on the previous edge.
- all_agree  output  1  a == b == c on the voted sample.
- err_a  output  1  lane A differed from the majority in at least one bit.
- err_b  output  1  lane B differed from the majority in at least one bit.
- err_c  output  1  lane C differed from the majority in at least one bit.
- fault_cnt_a  output  CNT_W  count of voted samples on which err_a was raised.
- fault_cnt_b  output  CNT_W  count of voted samples on which err_b was raised.
- fault_cnt_c  output  CNT_W  count of voted samples on which err_c was raised.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. rst is sampled only at the rising edge of clk.
- Reset: y=0, y_valid=0, all_agree=0, err_a/b/c=0, fault_cnt_a/b/c=0. rst overrides in_valid and clr_cnt.
- Majority function: maj = (a&b) | (a&c) | (b&c), evaluated bit by bit. Each bit is voted independently; there is no "no-majority" case.
- Latency: 1 cycle. Inputs are sampled at edge N when in_valid=1; y, y_valid, all_agree and err_x are valid after edge N. Fully pipelined: a new sample is accepted every cycle with no bubbles.
- Cycle with in_valid=1:
  - y <= maj.
  - y_valid <= 1.
  - all_agree <= (a==b) && (b==c).
  - err_x <= (x != maj), for x in {a,b,c}.
- Cycle with in_valid=0:
  - y holds its previous value.
  - y_valid <= 0, all_agree <= 0, err_a/b/c <= 0.
- Error flags are not sticky; they describe only the most recent voted sample.
- At most one lane can err per bit position. Across different bits, multiple lanes can err in the same sample (e.g. a=01, b=10, c=00 -> maj=00, err_a=1, err_b=1).
- Counters:
  - fault_cnt_x increments by 1 on each edge where in_valid=1 and lane x mismatches maj.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - Each counter is independent; several can increment on the same edge.
- clr_cnt=1 sets all three counters to 0 on that edge. This takes priority over a simultaneous increment.
- clr_cnt does not affect y, y_valid, all_agree or err flags.
- Reset asserted mid-stream: all outputs return to reset values on that edge. The sample presented in that cycle is discarded.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=1, rst for 2 cycles, then in_valid=1 and sweep (a,b,c) through 000,001,010,011,100,101,110,111 -> y one cycle later = 0,0,0,1,0,1,1,1. all_agree=1 only for 000 and 111. err_c=1 for 001 and 110; err_b=1 for 010 and 101; err_a=1 for 100 and 011.
- Hold in_valid=0 after y=1 -> y stays 1, y_valid=0, err flags 0, counters unchanged.
- WIDTH=8, a=8'hFF, b=8'h0F, c=8'hF0 -> y=8'hFF, err_a=0, err_b=1, err_c=1, all_agree=0, fault_cnt_b and fault_cnt_c each +1.
- CNT_W=2, drive a=1,b=0,c=0 for 5 valid cycles -> fault_cnt_a = 1,2,3,3,3 (saturates); other counters stay 0.
- clr_cnt=1 in the same cycle as a lane-A mismatch -> fault_cnt_a=0 next cycle and err_a=1.
- Assert rst for one cycle mid-stream with in_valid=1, a=b=c=1 -> next cycle y=0, y_valid=0, all counters 0.

Source files
------------

// File: rtl/majority_voter.sv
// Registered bitwise 2-of-3 majority voter for triplicated logic, with per-lane
// disagreement flags and saturating per-lane fault counters for health monitoring.
module majority_voter #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic             in_valid,
   input  logic             clr_cnt,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   output logic             all_agree,
   output logic             err_a,
   output logic             err_b,
   output logic             err_c,
   output logic [CNT_W-1:0] fault_cnt_a,
   output logic [CNT_W-1:0] fault_cnt_b,
   output logic [CNT_W-1:0] fault_cnt_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] w_maj;
   logic             w_err_a;
   logic             w_err_b;
   logic             w_err_c;
   logic             w_agree;

   // Each bit is voted independently, so a single lane can only lose a given bit.
   assign w_maj   = (a & b) | (a & c) | (b & c);
   assign w_err_a = |(a ^ w_maj);
   assign w_err_b = |(b ^ w_maj);
   assign w_err_c = |(c ^ w_maj);
   assign w_agree = (a == b) && (b == c);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             hit);
      return (hit && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;
   endfunction

   // NOTE: all state is written with <= so every register samples pre-edge values;
   // blocking assignments here would let later statements see already-updated state.
   always_ff @(posedge clk) begin
      if (rst) begin
         y           <= '0;
         y_valid     <= 1'b0;
         all_agree   <= 1'b0;
         err_a       <= 1'b0;
         err_b       <= 1'b0;
         err_c       <= 1'b0;
         fault_cnt_a <= '0;
         fault_cnt_b <= '0;
         fault_cnt_c <= '0;
      end else begin
         if (in_valid) begin
            y         <= w_maj;
            y_valid   <= 1'b1;
            all_agree <= w_agree;
            err_a     <= w_err_a;
            err_b     <= w_err_b;
            err_c     <= w_err_c;
         end else begin
            y_valid   <= 1'b0;
            all_agree <= 1'b0;
            err_a     <= 1'b0;
            err_b     <= 1'b0;
            err_c     <= 1'b0;
         end

         // A clear wins over a same-edge increment.
         if (clr_cnt) begin
            fault_cnt_a <= '0;
            fault_cnt_b <= '0;
            fault_cnt_c <= '0;
         end else if (in_valid) begin
            fault_cnt_a <= sat_inc(fault_cnt_a, w_err_a);
            fault_cnt_b <= sat_inc(fault_cnt_b, w_err_b);
            fault_cnt_c <= sat_inc(fault_cnt_c, w_err_c);
         end
      end
   end

endmodule

// File: tb/tb_majority_voter.sv
// Self-checking bench for majority_voter: a per-bit vote-counting model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_majority_voter;

   localparam int WIDTH = 8;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] a = '0, b = '0, c = '0;
   logic             in_valid = 1'b0;
   logic             clr_cnt = 1'b0;
   logic [WIDTH-1:0] y;
   logic             y_valid, all_agree, err_a, err_b, err_c;
   logic [CNT_W-1:0] fault_cnt_a, fault_cnt_b, fault_cnt_c;

   int n_cmp = 0;
   int n_bad = 0;

   majority_voter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
      .in_valid(in_valid), .clr_cnt(clr_cnt),
      .y(y), .y_valid(y_valid), .all_agree(all_agree),
      .err_a(err_a), .err_b(err_b), .err_c(err_c),
      .fault_cnt_a(fault_cnt_a), .fault_cnt_b(fault_cnt_b), .fault_cnt_c(fault_cnt_c)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: vote by counting ones per bit position.
   function automatic logic [WIDTH-1:0] vote(input logic [WIDTH-1:0] x0, x1, x2);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         int ones;
         ones = int'(x0[i]) + int'(x1[i]) + int'(x2[i]);
         r[i] = (ones >= 2);
      end
      return r;
   endfunction

   bit               m_known = 1'b0;
   logic [WIDTH-1:0] m_y;
   bit               m_yv, m_agree, m_ea, m_eb, m_ec;
   int               m_ca, m_cb, m_cc;

   always @(posedge clk) begin
      logic [WIDTH-1:0] v;
      v = vote(a, b, c);
      if (rst) begin
         m_known <= 1'b1;
         m_y <= '0; m_yv <= 0; m_agree <= 0; m_ea <= 0; m_eb <= 0; m_ec <= 0;
         m_ca <= 0; m_cb <= 0; m_cc <= 0;
      end else begin
         m_yv    <= in_valid;
         m_agree <= in_valid && (a == b) && (b == c);
         m_ea    <= in_valid && (a != v);
         m_eb    <= in_valid && (b != v);
         m_ec    <= in_valid && (c != v);
         if (in_valid) m_y <= v;
         if (clr_cnt) begin
            m_ca <= 0; m_cb <= 0; m_cc <= 0;
         end else if (in_valid) begin
            m_ca <= (a != v) ? ((m_ca + 1 > CMAX) ? CMAX : m_ca + 1) : m_ca;
            m_cb <= (b != v) ? ((m_cb + 1 > CMAX) ? CMAX : m_cb + 1) : m_cb;
            m_cc <= (c != v) ? ((m_cc + 1 > CMAX) ? CMAX : m_cc + 1) : m_cc;
         end
      end
   end

   always @(negedge clk) begin
      if (m_known) begin
         check("model_y",         32'(y),           32'(m_y));
         check("model_y_valid",   32'(y_valid),     32'(m_yv));
         check("model_all_agree", 32'(all_agree),   32'(m_agree));
         check("model_err_a",     32'(err_a),       32'(m_ea));
         check("model_err_b",     32'(err_b),       32'(m_eb));
         check("model_err_c",     32'(err_c),       32'(m_ec));
         check("model_cnt_a",     32'(fault_cnt_a), 32'(m_ca));
         check("model_cnt_b",     32'(fault_cnt_b), 32'(m_cb));
         check("model_cnt_c",     32'(fault_cnt_c), 32'(m_cc));
      end
   end

   task automatic step(input logic [WIDTH-1:0] ta, tb, tc, input logic v, input logic clr);
      a = ta; b = tb; c = tc; in_valid = v; clr_cnt = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [WIDTH-1:0] ey, input logic ev,
                             input logic eg, input logic [2:0] eerr, input int ca, cb, cc);
      check({tag, "_y"},       32'(y),           32'(ey));
      check({tag, "_y_valid"}, 32'(y_valid),     32'(ev));
      check({tag, "_agree"},   32'(all_agree),   32'(eg));
      check({tag, "_errs"},    32'({err_a, err_b, err_c}), 32'(eerr));
      check({tag, "_cnt_a"},   32'(fault_cnt_a), 32'(ca));
      check({tag, "_cnt_b"},   32'(fault_cnt_b), 32'(cb));
      check({tag, "_cnt_c"},   32'(fault_cnt_c), 32'(cc));
   endtask

   initial begin
      logic [7:0]  y_tab;
      logic [7:0]  ag_tab;
      logic [23:0] err_tab;
      logic [2:0]  v3;

      // Index = {a,b,c}; entries hand-computed from the 1-bit truth table.
      y_tab   = 8'b1110_1000;
      ag_tab  = 8'b1000_0001;
      err_tab = {3'b000, 3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000};

      @(posedge clk); #1;
      rst = 1'b1;
      step('0, '0, '0, 1'b0, 1'b0);
      step('0, '0, '0, 1'b0, 1'b0);
      rst = 1'b0;
      expect_out("reset", 8'h00, 0, 0, 3'b000, 0, 0, 0);

      for (int i = 0; i < 8; i++) begin
         v3 = 3'(i);
         step({WIDTH{v3[2]}}, {WIDTH{v3[1]}}, {WIDTH{v3[0]}}, 1'b1, 1'b0);
         check($sformatf("sweep%0d_y", i),     32'(y),         32'({WIDTH{y_tab[i]}}));
         check($sformatf("sweep%0d_agree", i), 32'(all_agree), 32'(ag_tab[i]));
         check($sformatf("sweep%0d_errs", i),  32'({err_a, err_b, err_c}),
               32'(err_tab[3*i +: 3]));
      end
      expect_out("sweep_end", 8'hFF, 1, 1, 3'b000, 2, 2, 2);

      step('0, '0, '0, 1'b0, 1'b0);
      expect_out("hold", 8'hFF, 0, 0, 3'b000, 2, 2, 2);
      step('0, '0, '0, 1'b0, 1'b1);
      expect_out("clear_idle", 8'hFF, 0, 0, 3'b000, 0, 0, 0);

      step(8'hFF, 8'h0F, 8'hF0, 1'b1, 1'b0);
      expect_out("wide", 8'hFF, 1, 0, 3'b011, 0, 1, 1);
      step(8'h01, 8'h02, 8'h00, 1'b1, 1'b0);
      expect_out("two_lanes", 8'h00, 1, 0, 3'b110, 1, 2, 1);
      step('0, '0, '0, 1'b0, 1'b1);

      for (int i = 0; i < 5; i++) begin
         step(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
         check($sformatf("sat%0d_cnt_a", i), 32'(fault_cnt_a), 32'((i < 3) ? i + 1 : 3));
         check($sformatf("sat%0d_cnt_bc", i), 32'({fault_cnt_b, fault_cnt_c}), 32'(0));
      end

      step(8'h01, 8'h00, 8'h00, 1'b1, 1'b1);
      expect_out("clr_vs_inc", 8'h00, 1, 0, 3'b100, 0, 0, 0);

      for (int i = 0; i < 40; i++)
         step(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 9) == 0));

      step(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
      rst = 1'b1;
      step(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
      rst = 1'b0;
      expect_out("mid_reset", 8'h00, 0, 0, 3'b000, 0, 0, 0);
      step(8'hA5, 8'hA5, 8'h5A, 1'b1, 1'b0);
      expect_out("after_reset", 8'hA5, 1, 0, 3'b001, 0, 0, 1);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
